// File: rtl/sync_fifo_stat.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, synchronous flush, sticky overflow/underflow flags and a choice of
// first-word-fall-through or registered (1-cycle latency) read.
module sync_fifo_stat #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_TH   = 12,
    parameter int unsigned AEMPTY_TH  = 2,
    parameter bit          FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned         Depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt  = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH:0] AfullCnt  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AemptyCnt = (ADDR_WIDTH + 1)'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0] CntOne    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

    // Threshold legality, checked at elaboration
    if (AFULL_TH < 1 || AFULL_TH > Depth) begin : g_bad_afull
        $error("sync_fifo_stat: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH > Depth - 1) begin : g_bad_aempty
        $error("sync_fifo_stat: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags decode straight from the registered count
    assign wfull         = (count_q == DepthCnt);
    assign walmost_full  = (count_q >= AfullCnt);
    assign rempty        = (count_q == '0);
    assign ralmost_empty = (count_q <= AemptyCnt);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // Acceptance is judged on pre-edge full/empty; flush blocks both sides
    assign wr_acc = winc && !wfull && !flush;
    assign rd_acc = rinc && !rempty && !flush;

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PtrOne;
            if (rd_acc) rptr_d = rptr_q + PtrOne;
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CntOne;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CntOne;
            end
        end
        // A new error event wins over a clear in the same cycle
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (winc && wfull)  overflow_d  = 1'b1;
        if (rinc && rempty) underflow_d = 1'b1;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_q] <= wdata;
    end

    if (FWFT) begin : g_fwft
        // Head word is shown combinationally whenever the FIFO holds data
        assign rdata  = mem[rptr_q];
        assign rvalid = !rempty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        // Registered read: data captured on an accepted pop, valid for one cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem[rptr_q];
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_stat.sv
module tb_sync_fifo_stat;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // FWFT instance signals
    logic       flush = 0, winc = 0, rinc = 0, clr_err = 0;
    logic [7:0] wdata = 0, rdata;
    logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
    logic [4:0] count;

    // Registered-read instance signals
    logic       r_flush = 0, r_winc = 0, r_rinc = 0, r_clr_err = 0;
    logic [7:0] r_wdata = 0, r_rdata;
    logic       r_wfull, r_walmost_full, r_rvalid, r_rempty, r_ralmost_empty;
    logic       r_overflow, r_underflow;
    logic [4:0] r_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_stat #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(2),
                     .FWFT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
        .wfull(wfull), .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata),
        .rvalid(rvalid), .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_stat #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(2),
                     .FWFT(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .flush(r_flush), .winc(r_winc), .wdata(r_wdata),
        .wfull(r_wfull), .walmost_full(r_walmost_full), .rinc(r_rinc), .rdata(r_rdata),
        .rvalid(r_rvalid), .rempty(r_rempty), .ralmost_empty(r_ralmost_empty),
        .count(r_count), .overflow(r_overflow), .underflow(r_underflow),
        .clr_err(r_clr_err)
    );

    typedef struct {
        logic       winc, rinc, flush, clr;
        logic [7:0] wdata;
        logic       chk;        // compare pre-edge head word
        logic [7:0] exp_rdata;
        int         exp_count;  // after the edge
        logic       exp_ovf, exp_udf;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] model_q[$];
    int   wr_acc_cnt;
    logic w, r;
    logic [7:0] d;
    int   s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic wi, input logic ri, input logic fl, input logic cl,
                                input logic [7:0] wd, input logic ck, input logic [7:0] er,
                                input int ec, input logic eo, input logic eu);
        vec_t v;
        v.winc = wi; v.rinc = ri; v.flush = fl; v.clr = cl; v.wdata = wd;
        v.chk = ck; v.exp_rdata = er; v.exp_count = ec; v.exp_ovf = eo; v.exp_udf = eu;
        tbl.push_back(v);
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, count, 0);
        chk({tag, " rempty"}, rempty, 1);
        chk({tag, " ralmost_empty"}, ralmost_empty, 1);
        chk({tag, " wfull"}, wfull, 0);
        chk({tag, " walmost_full"}, walmost_full, 0);
        chk({tag, " rvalid"}, rvalid, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " underflow"}, underflow, 0);
        chk({tag, " r_count"}, r_count, 0);
        chk({tag, " r_rempty"}, r_rempty, 1);
        chk({tag, " r_ralmost_empty"}, r_ralmost_empty, 1);
        chk({tag, " r_wfull"}, r_wfull, 0);
        chk({tag, " r_walmost_full"}, r_walmost_full, 0);
        chk({tag, " r_rvalid"}, r_rvalid, 0);
        chk({tag, " r_rdata"}, r_rdata, 0);
        chk({tag, " r_overflow"}, r_overflow, 0);
        chk({tag, " r_underflow"}, r_underflow, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: winc rinc flush clr wdata chk exp_rdata exp_count ovf udf
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(i), 0, 0, i + 1, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 0, 1, 8'(i), 15 - i, 0, 0);
        add(1, 1, 0, 0, 8'h55, 0, 0, 1, 0, 1);           // empty: write wins, underflow
        add(0, 1, 0, 0, 0, 1, 8'h55, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(8'h10 + i), 0, 0, i + 1, 0, 0);
        add(1, 1, 0, 0, 8'hAA, 1, 8'h10, 15, 1, 0);      // full: pop wins, overflow
        for (int i = 0; i < 15; i++) add(0, 1, 0, 0, 0, 1, 8'(8'h11 + i), 14 - i, 1, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 8'(8'h20 + i), 0, 0, i + 1, 1, 0);
        add(1, 0, 1, 0, 8'h77, 0, 0, 0, 1, 0);           // flush drops the write
        add(1, 0, 0, 0, 8'h30, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 1, 8'h30, 0, 1, 0);
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(8'h40 + i), 0, 0, i + 1, 1, 0);
        add(1, 0, 0, 1, 8'hEE, 0, 0, 16, 1, 0);          // set beats clear
        add(0, 0, 0, 1, 0, 0, 0, 16, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 0, 1, 8'(8'h40 + i), 15 - i, 0, 0);

        #2;
        chk_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            winc = v.winc; rinc = v.rinc; flush = v.flush; clr_err = v.clr; wdata = v.wdata;
            if (v.chk) chk($sformatf("v%0d rdata", i), rdata, v.exp_rdata);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), count, v.exp_count);
            chk($sformatf("v%0d wfull", i), wfull, v.exp_count == 16);
            chk($sformatf("v%0d walmost_full", i), walmost_full, v.exp_count >= 12);
            chk($sformatf("v%0d rempty", i), rempty, v.exp_count == 0);
            chk($sformatf("v%0d ralmost_empty", i), ralmost_empty, v.exp_count <= 2);
            chk($sformatf("v%0d rvalid", i), rvalid, v.exp_count != 0);
            chk($sformatf("v%0d overflow", i), overflow, v.exp_ovf);
            chk($sformatf("v%0d underflow", i), underflow, v.exp_udf);
        end
        @(negedge clk);
        winc = 0; rinc = 0; flush = 0; clr_err = 0;

        // Random interleave against a queue model, 40 accepted writes
        wr_acc_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (wr_acc_cnt >= 40 && model_q.size() == 0) break;
            w = (wr_acc_cnt < 40) && ($urandom_range(0, 99) < 55);
            r = (wr_acc_cnt >= 40) || ($urandom_range(0, 99) < 45);
            d = 8'($urandom);
            @(negedge clk);
            winc = w; rinc = r; wdata = d;
            s = model_q.size();
            if (r && s != 0) chk("rnd rdata", rdata, model_q[0]);
            @(posedge clk);
            #1;
            if (r && s != 0) void'(model_q.pop_front());
            if (w && s != 16) begin
                model_q.push_back(d);
                wr_acc_cnt++;
            end
            chk("rnd count", count, model_q.size());
            chk("rnd count_le_16", count <= 16, 1);
        end
        chk("rnd accepted writes", wr_acc_cnt, 40);
        chk("rnd drained", model_q.size(), 0);
        @(negedge clk);
        winc = 0; rinc = 0;

        // Registered-read instance
        @(negedge clk);
        r_winc = 1; r_wdata = 8'h3C;
        @(negedge clk);
        r_winc = 0; r_rinc = 1;
        chk("reg rvalid before pop", r_rvalid, 0);
        @(posedge clk);
        #1;
        chk("reg rvalid after pop", r_rvalid, 1);
        chk("reg rdata after pop", r_rdata, 8'h3C);
        chk("reg count after pop", r_count, 0);
        @(negedge clk);
        r_rinc = 0;
        @(posedge clk);
        #1;
        chk("reg rvalid pulse ends", r_rvalid, 0);
        chk("reg rdata holds", r_rdata, 8'h3C);
        @(negedge clk);
        r_rinc = 1;
        @(posedge clk);
        #1;
        chk("reg underflow", r_underflow, 1);
        chk("reg rvalid on empty pop", r_rvalid, 0);
        @(negedge clk);
        r_rinc = 0; r_winc = 1; r_wdata = 8'h11;
        @(negedge clk);
        r_rinc = 1; r_wdata = 8'h22;
        @(posedge clk);
        #1;
        chk("reg burst rdata", r_rdata, 8'h11);
        chk("reg burst rvalid", r_rvalid, 1);
        chk("reg burst count", r_count, 1);
        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset");
        @(negedge clk);
        r_winc = 0; r_rinc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset r_count", r_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
